// File: rtl/axi_wr_burst_arbiter_if.sv
// axi_wr_burst_arbiter_if: requester FIFO heads/pops plus the shared AXI write channels
interface axi_wr_burst_arbiter_if #(
   parameter int NUM_REQ = 8,
   parameter int CMD_W = 97,
   parameter int DATA_W = 512,
   parameter int ID_W = 8
);
   logic [NUM_REQ-1:0] cmd_empty, cmd_rd, dat_empty, dat_rd, grant;
   logic [NUM_REQ*CMD_W-1:0] cmd_data;
   logic [NUM_REQ*DATA_W-1:0] dat_data;
   logic awvalid, awready;
   logic [63:0] awaddr;
   logic [7:0] awlen;
   logic [2:0] awsize;
   logic [ID_W-1:0] awid;
   logic wvalid, wready, wlast;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic bvalid, bready, resp_err;
   logic [1:0] bresp;
   logic [ID_W-1:0] bid;
   modport master (
      input cmd_empty, cmd_data, dat_empty, dat_data, awready, wready, bvalid, bresp, bid,
      output cmd_rd, dat_rd, grant, awvalid, awaddr, awlen, awsize, awid,
      output wvalid, wdata, wstrb, wlast, bready, resp_err
   );
   modport slave (
      output cmd_empty, cmd_data, dat_empty, dat_data, awready, wready, bvalid, bresp, bid,
      input cmd_rd, dat_rd, grant, awvalid, awaddr, awlen, awsize, awid,
      input wvalid, wdata, wstrb, wlast, bready, resp_err
   );
endinterface

// File: rtl/axi_wr_burst_arbiter.sv
// axi_wr_burst_arbiter: round-robin sharing of one AXI write port among NUM_REQ command/data FIFO pairs
module axi_wr_burst_arbiter #(
   parameter int NUM_REQ = 8,
   parameter int CMD_W = 97,
   parameter int DATA_W = 512,
   parameter int ID_W = 8
) (
   input logic clk,
   input logic resetn,
   axi_wr_burst_arbiter_if.master bus
);
   localparam int SW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
   state_t state, state_nxt;
   logic [SW-1:0] sel, last_grant, win;
   logic [CMD_W-1:0] cmd_head;
   logic [63:0] addr_q;
   logic [7:0] len_q, beat_cnt;
   logic [2:0] size_q;
   logic [ID_W-1:0] id_q;
   logic req_any, aw_hs, w_vld, w_hs, resp_err_q, unused_bits;
   assign req_any = ~&bus.cmd_empty;
   assign aw_hs = state == AW && bus.awready;
   assign w_vld = state == W && !bus.dat_empty[sel];
   assign w_hs = w_vld && bus.wready;
   assign cmd_head = bus.cmd_data[int'(win)*CMD_W +: CMD_W];
   assign unused_bits = ^{cmd_head[CMD_W-1:75+ID_W], bus.bresp[0]};
   // descending scan so the nearest requester after last_grant wins
   always_comb begin
      win = '0;
      for (int i = NUM_REQ; i >= 1; i--)
         if (!bus.cmd_empty[last_grant + SW'(i)]) win = last_grant + SW'(i);
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = req_any ? AW : IDLE;
         AW: state_nxt = bus.awready ? W : AW;
         W: state_nxt = (w_hs && beat_cnt == len_q) ? B : W;
         B: state_nxt = bus.bvalid ? IDLE : B;
      endcase
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         sel <= '0;
         last_grant <= SW'(NUM_REQ - 1);
         addr_q <= '0;
         len_q <= '0;
         size_q <= '0;
         id_q <= '0;
         beat_cnt <= '0;
         resp_err_q <= 1'b0;
      end else begin
         if (state == IDLE && req_any) begin
            sel <= win;
            addr_q <= cmd_head[63:0];
            len_q <= cmd_head[71:64];
            size_q <= cmd_head[74:72];
            id_q <= cmd_head[75 +: ID_W];
         end
         if (aw_hs) beat_cnt <= '0;
         else if (w_hs) beat_cnt <= beat_cnt + 8'd1;
         if (state == B && bus.bvalid) last_grant <= sel;
         resp_err_q <= state == B && bus.bvalid && (bus.bresp[1] || bus.bid != id_q);
      end
   // cmd_rd is gated by resetn so no FIFO is popped while held in reset
   always_comb begin
      bus.cmd_rd = (state == IDLE && req_any && resetn) ? NUM_REQ'(1) << win : '0;
      bus.grant = state == IDLE ? '0 : NUM_REQ'(1) << sel;
      bus.awvalid = state == AW;
      bus.awaddr = addr_q;
      bus.awlen = len_q;
      bus.awsize = size_q;
      bus.awid = id_q;
      bus.wvalid = w_vld;
      bus.wdata = state == W ? bus.dat_data[int'(sel)*DATA_W +: DATA_W] : '0;
      bus.wstrb = '1;
      bus.wlast = w_vld && beat_cnt == len_q;
      bus.dat_rd = w_hs ? NUM_REQ'(1) << sel : '0;
      bus.bready = state == B;
      bus.resp_err = resp_err_q;
   end
endmodule

// File: tb/tb_axi_wr_burst_arbiter.sv
// tb_axi_wr_burst_arbiter: FIFO/AXI-slave emulation with a burst-level round-robin reference model
module tb_axi_wr_burst_arbiter;
   localparam int N = 8, CW = 97, DW = 64, IW = 8;
   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;
   axi_wr_burst_arbiter_if #(.NUM_REQ(N), .CMD_W(CW), .DATA_W(DW), .ID_W(IW)) bus ();
   axi_wr_burst_arbiter #(.NUM_REQ(N), .CMD_W(CW), .DATA_W(DW), .ID_W(IW)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );
   logic [CW-1:0] cq [N][$];
   logic [DW-1:0] dq [N][$];
   logic [CW-1:0] cur_cmd;
   logic [N-1:0] stall;
   logic [1:0] b_resp_next;
   logic [IW-1:0] bid_xor;
   logic [DW/8-1:0] ones = '1;
   int cur, last, beats, b_wait, awr_mode, wr_mode, wlast_cnt, err_cnt, rd_cnt;
   bit aw_done, w_done, err_pend;
   int order[$];
   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int r = 0; r < N; r++) s += cq[r].size();
      return s;
   endfunction

   task automatic add(input int r, input int len);
      logic [CW-1:0] c;
      c = '0;
      c[63:0] = {$urandom, $urandom};
      c[71:64] = 8'(len);
      c[74:72] = 3'($urandom);
      c[82:75] = 8'($urandom);
      c[96:83] = 14'($urandom);
      cq[r].push_back(c);
      for (int k = 0; k <= len; k++) dq[r].push_back({$urandom, $urandom});
   endtask

   task automatic clear_model();
      for (int r = 0; r < N; r++) begin
         cq[r].delete();
         dq[r].delete();
      end
      cur = -1; last = N - 1; beats = 0; b_wait = 0;
      aw_done = 0; w_done = 0; err_pend = 0; stall = '0;
      order.delete();
   endtask

   task automatic drive();
      for (int r = 0; r < N; r++) begin
         bus.cmd_empty[r] = cq[r].size() == 0;
         bus.cmd_data[r*CW +: CW] = cq[r].size() != 0 ? cq[r][0] : '0;
         bus.dat_empty[r] = dq[r].size() == 0 || stall[r];
         bus.dat_data[r*DW +: DW] = dq[r].size() != 0 ? dq[r][0] : '0;
      end
      bus.awready = awr_mode == 0 ? 1'($urandom_range(0, 1)) : awr_mode == 2;
      bus.wready = wr_mode == 0 ? 1'($urandom_range(0, 1)) : wr_mode == 2;
      bus.bvalid = 1'b0;
      bus.bresp = 2'($urandom);
      bus.bid = 8'($urandom);
      if (cur >= 0 && w_done) begin
         if (b_wait == 0) begin
            bus.bvalid = 1'b1;
            bus.bresp = b_resp_next;
            bus.bid = cur_cmd[82:75] ^ bid_xor;
         end else b_wait--;
      end
   endtask

   // one clock: drive at negedge, compare 1ns later, then commit what the next posedge accepts
   task automatic cyc();
      int win;
      bit v;
      @(negedge clk);
      drive();
      #1;
      if (bus.wvalid && bus.wready && bus.wlast) wlast_cnt++;
      if (bus.resp_err) err_cnt++;
      if (bus.cmd_rd != '0) rd_cnt++;
      chk("resp_err", bus.resp_err, err_pend);
      err_pend = 0;
      chk("wstrb", bus.wstrb, ones);
      if (cur < 0) begin
         win = -1;
         for (int k = 1; k <= N; k++)
            if (win < 0 && cq[(last + k) % N].size() != 0) win = (last + k) % N;
         chk("cmd_rd", bus.cmd_rd, win < 0 ? 0 : 1 << win);
         chk("idle_grant", bus.grant, 0);
         chk("idle_awvalid", bus.awvalid, 0);
         chk("idle_wvalid", bus.wvalid, 0);
         chk("idle_bready", bus.bready, 0);
         if (win >= 0) begin
            cur = win;
            cur_cmd = cq[win].pop_front();
            aw_done = 0; w_done = 0; beats = 0;
            b_wait = $urandom_range(0, 3);
            order.push_back(win);
         end
      end else begin
         chk("grant", bus.grant, 1 << cur);
         chk("busy_cmd_rd", bus.cmd_rd, 0);
         if (!aw_done) begin
            chk("awvalid", bus.awvalid, 1);
            chk("awaddr", bus.awaddr, cur_cmd[63:0]);
            chk("awlen", bus.awlen, cur_cmd[71:64]);
            chk("awsize", bus.awsize, cur_cmd[74:72]);
            chk("awid", bus.awid, cur_cmd[82:75]);
            chk("aw_wvalid", bus.wvalid, 0);
            chk("aw_dat_rd", bus.dat_rd, 0);
            if (bus.awready) aw_done = 1;
         end else if (!w_done) begin
            v = dq[cur].size() != 0 && !stall[cur];
            chk("wvalid", bus.wvalid, v);
            chk("wlast", bus.wlast, v && beats == int'(cur_cmd[71:64]));
            if (v) chk("wdata", bus.wdata, dq[cur][0]);
            chk("dat_rd", bus.dat_rd, (v && bus.wready) ? 1 << cur : 0);
            chk("w_awvalid", bus.awvalid, 0);
            chk("w_bready", bus.bready, 0);
            if (v && bus.wready) begin
               void'(dq[cur].pop_front());
               beats++;
               if (beats == int'(cur_cmd[71:64]) + 1) w_done = 1;
            end
         end else begin
            chk("bready", bus.bready, 1);
            chk("b_wvalid", bus.wvalid, 0);
            chk("b_dat_rd", bus.dat_rd, 0);
            if (bus.bvalid) begin
               err_pend = bus.bresp[1] || bus.bid != cur_cmd[82:75];
               last = cur;
               cur = -1;
            end
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (n < budget && (cur >= 0 || pending() != 0)) begin
         cyc();
         n++;
      end
      chk("drain_left", pending() + (cur >= 0 ? 1 : 0), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_cmd_rd", bus.cmd_rd, 0);
      chk("rst_dat_rd", bus.dat_rd, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_awvalid", bus.awvalid, 0);
      chk("rst_awaddr", bus.awaddr, 0);
      chk("rst_wvalid", bus.wvalid, 0);
      chk("rst_wlast", bus.wlast, 0);
      chk("rst_bready", bus.bready, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      chk("rst_wstrb", bus.wstrb, ones);
      clear_model();
      drive();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      awr_mode = 2; wr_mode = 2; b_resp_next = 2'b00; bid_xor = '0;
      wlast_cnt = 0; err_cnt = 0; rd_cnt = 0;
      clear_model();
      drive();
      do_reset();
      // single requester, 4-beat burst
      add(3, 3);
      drain(60);
      chk("t1_winner", order.size() == 1 ? order[0] : -1, 3);
      chk("t1_wlast_cnt", wlast_cnt, 1);
      chk("t1_cmd_pops", rd_cnt, 1);
      chk("t1_data_left", dq[3].size(), 0);
      // everyone pending, single-beat bursts
      do_reset();
      wlast_cnt = 0;
      for (int r = 0; r < N; r++) add(r, 0);
      add(0, 0);
      drain(300);
      chk("t2_bursts", order.size(), 9);
      for (int i = 0; i < 9; i++) chk("t2_grant_order", i < order.size() ? order[i] : -1, i % N);
      chk("t2_wlast_cnt", wlast_cnt, 9);
      // AW back-pressure
      awr_mode = 1;
      add(1, 2);
      repeat (7) cyc();
      chk("t3_aw_hold", bus.awvalid, 1);
      chk("t3_no_w", bus.wvalid, 0);
      awr_mode = 2;
      drain(60);
      // data underrun mid-burst
      wlast_cnt = 0;
      add(6, 7);
      for (int k = 0; k < 80 && (cur >= 0 || pending() != 0); k++) begin
         stall = (k % 3 == 1) ? N'(8'h40) : '0;
         cyc();
      end
      stall = '0;
      drain(60);
      chk("t4_wlast_cnt", wlast_cnt, 1);
      chk("t4_data_left", dq[6].size(), 0);
      // error responses
      err_cnt = 0;
      b_resp_next = 2'b10;
      add(2, 1);
      drain(60);
      b_resp_next = 2'b00;
      bid_xor = 8'h01;
      add(4, 0);
      drain(60);
      bid_xor = '0;
      cyc();
      chk("t5_err_pulses", err_cnt, 2);
      add(5, 0);
      drain(60);
      cyc();
      chk("t5_err_after_ok", err_cnt, 2);
      // reset during the second W beat
      add(5, 5);
      for (int k = 0; k < 40 && !(cur >= 0 && aw_done && beats == 1); k++) cyc();
      do_reset();
      add(2, 0);
      add(0, 0);
      drain(60);
      chk("t6_first", order.size() > 0 ? order[0] : -1, 0);
      chk("t6_second", order.size() > 1 ? order[1] : -1, 2);
      // random traffic
      awr_mode = 0; wr_mode = 0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 7) == 0) add($urandom_range(0, N - 1), $urandom_range(0, 7));
         stall = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         b_resp_next = 2'($urandom);
         bid_xor = ($urandom_range(0, 5) == 0) ? 8'h80 : '0;
         cyc();
      end
      stall = '0;
      drain(5000);
      bid_xor = '0;
      repeat (3) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
